// File: rtl/ibex_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ibex_mem_arb_pkg
// Description : Shared types and helpers for the Ibex instruction/data
//               memory arbiter (host IDs, outstanding-depth range check,
//               order-FIFO pointer sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package ibex_mem_arb_pkg;

   // Host identifier; also the payload stored in the order FIFO.
   typedef enum logic {
      HostInstr = 1'b0,
      HostData  = 1'b1
   } arb_host_e;

   // Legal range for the number of device transactions in flight.
   localparam int unsigned MaxOutstandingMin = 1;
   localparam int unsigned MaxOutstandingMax = 8;

   // True when the requested outstanding depth is supported.
   function automatic logic max_outstanding_legal(input int unsigned n);
      return (n >= MaxOutstandingMin) && (n <= MaxOutstandingMax);
   endfunction

   // Pointer width for a FIFO of the given depth; never narrower than 1 bit
   // so a depth-1 FIFO still has a real pointer register.
   function automatic int unsigned arb_ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage : ibex_mem_arb_pkg
`default_nettype wire

// File: rtl/ibex_mem_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ibex_mem_arb_fifo
// Description : 1-bit wide order FIFO remembering which host issued each
//               granted device transaction, so in-order responses can be
//               routed back. Pointers wrap modulo Depth.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_mem_arb_fifo
   import ibex_mem_arb_pkg::*;
#(
   parameter  int unsigned Depth = 2,
   localparam int unsigned PtrW  = arb_ptr_width(Depth),
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  arb_host_e       push_host_i,
   input  logic            pop_i,
   output arb_host_e       head_o,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o
);

   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   // Storage is sized to the full pointer range so every pointer value
   // indexes a real bit; entries at or beyond Depth are never written.
   logic [(2**PtrW)-1:0]   mem_q, mem_d;
   logic                   push_ok;
   logic                   pop_ok;

   // Advance a pointer, wrapping after the last valid entry.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      if (p == PtrW'(Depth - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   // Next-state for storage, pointers and occupancy; pushes into a full
   // FIFO and pops from an empty one are ignored.
   always_comb begin
      push_ok  = push_i && (count_q != CntW'(Depth));
      pop_ok   = pop_i && (count_q != '0);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push_ok) begin
         mem_d[wr_ptr_q] = push_host_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers; reset empties the FIFO immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Status outputs derived from the registered occupancy.
   always_comb begin
      head_o  = arb_host_e'(mem_q[rd_ptr_q]);
      full_o  = (count_q == CntW'(Depth));
      empty_o = (count_q == '0);
      count_o = count_q;
   end

endmodule : ibex_mem_arb_fifo
`default_nettype wire

// File: rtl/ibex_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ibex_mem_arbiter
// Description : Shares one single-ported req/gnt/rvalid memory bus between
//               the Ibex instruction-fetch and data hosts. Round-robin or
//               fixed (data-first) arbitration, up to MaxOutstanding
//               in-order transactions, responses routed by an order FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_mem_arbiter
   import ibex_mem_arb_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter bit          FixedPrio      = 1'b0,
   parameter int unsigned IntgWidth      = 7
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   // Instruction host
   input  logic                 instr_req_i,
   output logic                 instr_gnt_o,
   input  logic [31:0]          instr_addr_i,
   output logic                 instr_rvalid_o,
   output logic [31:0]          instr_rdata_o,
   output logic [IntgWidth-1:0] instr_rdata_intg_o,
   output logic                 instr_err_o,

   // Data host
   input  logic                 data_req_i,
   input  logic                 data_we_i,
   input  logic [3:0]           data_be_i,
   input  logic [31:0]          data_addr_i,
   input  logic [31:0]          data_wdata_i,
   input  logic [IntgWidth-1:0] data_wdata_intg_i,
   output logic                 data_gnt_o,
   output logic                 data_rvalid_o,
   output logic [31:0]          data_rdata_o,
   output logic [IntgWidth-1:0] data_rdata_intg_o,
   output logic                 data_err_o,

   // Device
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [3:0]           mem_be_o,
   output logic [31:0]          mem_addr_o,
   output logic [31:0]          mem_wdata_o,
   output logic [IntgWidth-1:0] mem_wdata_intg_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [31:0]          mem_rdata_i,
   input  logic [IntgWidth-1:0] mem_rdata_intg_i,
   input  logic                 mem_err_i,

   output logic                 unexpected_rsp_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   // Reject unsupported outstanding depths at elaboration.
   if (!max_outstanding_legal(MaxOutstanding)) begin : g_bad_max_outstanding
      $error("ibex_mem_arbiter: MaxOutstanding must be within 1..8");
   end

   arb_host_e       last_q, last_d;
   arb_host_e       winner;
   logic            any_req;
   logic            accept;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   arb_host_e       fifo_head;
   logic [CntW-1:0] fifo_count;

   // Pick the winning host from the current requests; on a tie the data
   // host wins under fixed priority, otherwise the host not granted last.
   always_comb begin
      winner = HostInstr;
      case ({instr_req_i, data_req_i})
         2'b01:   winner = HostData;
         2'b10:   winner = HostInstr;
         2'b11:   winner = FixedPrio ? HostData
                                     : ((last_q == HostInstr) ? HostData : HostInstr);
         default: winner = HostInstr;
      endcase
   end

   // Device request mux and host grants. Request is blocked while the order
   // FIFO is full, independent of a same-cycle response, so there is no
   // combinational path from mem_rvalid_i to mem_req_o.
   always_comb begin
      any_req   = instr_req_i || data_req_i;
      mem_req_o = any_req && !fifo_full;
      accept    = mem_req_o && mem_gnt_i;

      if (winner == HostData) begin
         mem_addr_o = data_addr_i;
         mem_we_o   = data_we_i;
         mem_be_o   = data_be_i;
      end else begin
         mem_addr_o = instr_addr_i;
         mem_we_o   = 1'b0;
         mem_be_o   = 4'hF;
      end

      // Write data always follows the data host; it is ignored on reads.
      mem_wdata_o      = data_wdata_i;
      mem_wdata_intg_o = data_wdata_intg_i;

      instr_gnt_o = accept && (winner == HostInstr);
      data_gnt_o  = accept && (winner == HostData);
   end

   // Remember the last host whose grant was actually accepted.
   always_comb begin
      last_d = accept ? winner : last_q;
   end

   // Last-granted register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q <= HostInstr;
      end else begin
         last_q <= last_d;
      end
   end

   // Order FIFO: push the winner on every accepted grant, pop on response.
   ibex_mem_arb_fifo #(
      .Depth (MaxOutstanding)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (accept),
      .push_host_i (winner),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Response routing: the FIFO head steers rvalid; a response with nothing
   // outstanding is dropped and flagged instead.
   always_comb begin
      fifo_pop         = mem_rvalid_i && !fifo_empty;
      unexpected_rsp_o = mem_rvalid_i && fifo_empty;

      instr_rvalid_o = fifo_pop && (fifo_head == HostInstr);
      data_rvalid_o  = fifo_pop && (fifo_head == HostData);

      instr_rdata_o      = mem_rdata_i;
      instr_rdata_intg_o = mem_rdata_intg_i;
      instr_err_o        = mem_err_i;
      data_rdata_o       = mem_rdata_i;
      data_rdata_intg_o  = mem_rdata_intg_i;
      data_err_o         = mem_err_i;
   end

   // The full flag and the occupancy count must always agree.
   a_full_matches_count : assert property (
      @(posedge clk_i) disable iff (rst_i)
      fifo_full == (fifo_count == CntW'(MaxOutstanding))
   );

endmodule : ibex_mem_arbiter
`default_nettype wire
